// File: rtl/interpolator_upsampler.sv
// Upsampler that expands each decimated sample into Interpolation_factor outputs
// (zero-stuffed or held), with an input FIFO and valid/ready on both sides.
module interpolator_upsampler #(
  parameter int Data_bits            = 26,
  parameter int Interpolation_factor = 16,
  parameter bit Hold_mode            = 1'b0,
  parameter int Fifo_depth           = 4,
  localparam int Phase_bits = (Interpolation_factor > 1) ? $clog2(Interpolation_factor) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic signed [Data_bits-1:0] data_in,
  input  logic                        data_valid_i,
  output logic                        data_ready_o,
  output logic signed [Data_bits-1:0] data_out,
  output logic                        data_valid_o,
  input  logic                        data_ready_i,
  output logic [Phase_bits-1:0]       phase_o
);

  localparam int Addr_bits = $clog2(Fifo_depth);
  localparam logic [Addr_bits:0]  Full_count = Fifo_depth[Addr_bits:0];
  localparam logic [Phase_bits-1:0] Last_phase = Phase_bits'(Interpolation_factor - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  logic signed [Data_bits-1:0] mem [Fifo_depth];
  logic [Addr_bits-1:0] wr_ptr, rd_ptr;
  logic [Addr_bits:0]   count;
  logic                 ready_en;
  logic                 push, pop, empty, full;

  state_t                      state, state_next;
  logic signed [Data_bits-1:0] sample, sample_next, data_next;
  logic [Phase_bits-1:0]       phase_next;
  logic                        valid_next;

  assign empty        = (count == '0);
  assign full         = (count == Full_count);
  // ready_en keeps ready low through reset and releases it one edge later.
  assign data_ready_o = ready_en && !full;
  assign push         = data_valid_i && data_ready_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by count, so stale
  // contents are never observed and the array maps onto plain RAM/regs.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      sample       <= '0;
      data_out     <= '0;
      phase_o      <= '0;
      data_valid_o <= 1'b0;
    end else begin
      state        <= state_next;
      sample       <= sample_next;
      data_out     <= data_next;
      phase_o      <= phase_next;
      data_valid_o <= valid_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    sample_next = sample;
    data_next   = data_out;
    phase_next  = phase_o;
    valid_next  = data_valid_o;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (!empty) begin
          pop         = 1'b1;
          sample_next = mem[rd_ptr];
          data_next   = mem[rd_ptr];
          phase_next  = '0;
          valid_next  = 1'b1;
          state_next  = EMIT;
        end
      end
      EMIT: begin
        if (data_ready_i) begin
          if (phase_o != Last_phase) begin
            phase_next = phase_o + 1'b1;
            data_next  = Hold_mode ? sample : '0;
          end else if (!empty) begin
            // Chain straight into the next sample without a bubble.
            pop         = 1'b1;
            sample_next = mem[rd_ptr];
            data_next   = mem[rd_ptr];
            phase_next  = '0;
          end else begin
            phase_next = '0;
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  a_factor_range: assert property (@(posedge clk_i)
    (Interpolation_factor >= 1) && (Interpolation_factor <= 256));

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (data_valid_o && !data_ready_i) |=> (data_valid_o && $stable(data_out) && $stable(phase_o)));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));

endmodule

// File: tb/tb_interpolator_upsampler.sv
// Directed bench for interpolator_upsampler: four parameterisations share one
// input stimulus; each task checks the instance its scenario targets.
module tb_interpolator_upsampler;

  localparam int DW = 26;

  logic clk = 1'b0;
  logic rst_i;
  logic signed [DW-1:0] data_in;
  logic data_valid_i;
  logic data_ready_i;

  int checks = 0;
  int errors = 0;

  // u_d: IF=16 zero-stuff; u_h: IF=4 hold; u_b: IF=4 zero-stuff; u_1: IF=1
  logic signed [DW-1:0] d_data, h_data, b_data, o_data;
  logic d_valid, h_valid, b_valid, o_valid;
  logic d_ready, h_ready, b_ready, o_ready;
  logic [3:0] d_phase;
  logic [1:0] h_phase, b_phase;
  logic [0:0] o_phase;

  always #5 clk = ~clk;

  interpolator_upsampler #(.Data_bits(DW), .Interpolation_factor(16), .Hold_mode(1'b0), .Fifo_depth(4)) u_d (
    .clk_i(clk), .rst_i(rst_i), .data_in(data_in), .data_valid_i(data_valid_i), .data_ready_o(d_ready),
    .data_out(d_data), .data_valid_o(d_valid), .data_ready_i(data_ready_i), .phase_o(d_phase));

  interpolator_upsampler #(.Data_bits(DW), .Interpolation_factor(4), .Hold_mode(1'b1), .Fifo_depth(4)) u_h (
    .clk_i(clk), .rst_i(rst_i), .data_in(data_in), .data_valid_i(data_valid_i), .data_ready_o(h_ready),
    .data_out(h_data), .data_valid_o(h_valid), .data_ready_i(data_ready_i), .phase_o(h_phase));

  interpolator_upsampler #(.Data_bits(DW), .Interpolation_factor(4), .Hold_mode(1'b0), .Fifo_depth(4)) u_b (
    .clk_i(clk), .rst_i(rst_i), .data_in(data_in), .data_valid_i(data_valid_i), .data_ready_o(b_ready),
    .data_out(b_data), .data_valid_o(b_valid), .data_ready_i(data_ready_i), .phase_o(b_phase));

  interpolator_upsampler #(.Data_bits(DW), .Interpolation_factor(1), .Hold_mode(1'b0), .Fifo_depth(4)) u_1 (
    .clk_i(clk), .rst_i(rst_i), .data_in(data_in), .data_valid_i(data_valid_i), .data_ready_o(o_ready),
    .data_out(o_data), .data_valid_o(o_valid), .data_ready_i(data_ready_i), .phase_o(o_phase));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    data_in = '0;
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    data_in = '0;
    step();
    step();
    checks++;
    if (d_data !== '0 || d_valid !== 1'b0 || d_phase !== 4'd0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h valid=%b phase=%0d ready=%b, want 0 0 0 0",
               d_data, d_valid, d_phase, d_ready);
    end
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_if1: got ready=%b valid=%b, want 0 0", o_ready, o_valid);
    end
    rst_i = 1'b0;
    step();
    checks++;
    if (d_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got d=%b b=%b, want 1 1", d_ready, b_ready);
    end
  endtask

  task automatic test_zero_stuff();
    do_reset();
    data_ready_i = 1'b1;
    data_in = 26'h0000123;
    data_valid_i = 1'b1;
    checks++;
    if (d_ready !== 1'b1) begin
      errors++;
      $display("FAIL zs_ready: got %b, want 1", d_ready);
    end
    step();
    data_valid_i = 1'b0;
    data_in = '0;
    checks++;
    if (d_valid !== 1'b0) begin
      errors++;
      $display("FAIL zs_latency_early: got valid=%b, want 0", d_valid);
    end
    step();
    for (int p = 0; p < 16; p++) begin
      logic signed [DW-1:0] e;
      logic [3:0] ep;
      e = (p == 0) ? 26'sh0000123 : '0;
      ep = p[3:0];
      checks++;
      if (d_valid !== 1'b1 || d_data !== e || d_phase !== ep) begin
        errors++;
        $display("FAIL zs_out%0d: got valid=%b data=%h phase=%0d, want 1 %h %0d",
                 p, d_valid, d_data, d_phase, e, ep);
      end
      step();
    end
    checks++;
    if (d_valid !== 1'b0) begin
      errors++;
      $display("FAIL zs_valid_drop: got %b, want 0", d_valid);
    end
  endtask

  task automatic test_hold();
    do_reset();
    data_ready_i = 1'b1;
    data_valid_i = 1'b1;
    data_in = -26'sd5;
    step();
    data_in = 26'sd7;
    step();
    data_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic signed [DW-1:0] e;
      logic [1:0] ep;
      e = (i < 4) ? -26'sd5 : 26'sd7;
      ep = i[1:0];
      checks++;
      if (h_valid !== 1'b1 || h_data !== e || h_phase !== ep) begin
        errors++;
        $display("FAIL hold_out%0d: got valid=%b data=%0d phase=%0d, want 1 %0d %0d",
                 i, h_valid, h_data, h_phase, e, ep);
      end
      step();
    end
    checks++;
    if (h_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_valid_drop: got %b, want 0", h_valid);
    end
  endtask

  task automatic test_backpressure();
    int sent;
    int out_cnt;
    bit acc;
    do_reset();
    sent = 0;
    data_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      data_in = DW'(sent + 1);
      data_valid_i = (sent < 6);
      acc = data_valid_i && b_ready;
      step();
      if (acc) sent++;
    end
    checks++;
    if (sent != 5 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept_count: got accepted=%0d ready=%b, want 5 0", sent, b_ready);
    end
    checks++;
    if (b_valid !== 1'b1 || b_data !== 26'sd1 || b_phase !== 2'd0) begin
      errors++;
      $display("FAIL bp_frozen: got valid=%b data=%0d phase=%0d, want 1 1 0", b_valid, b_data, b_phase);
    end
    data_ready_i = 1'b1;
    out_cnt = 0;
    for (int cyc = 0; cyc < 100 && out_cnt < 24; cyc++) begin
      acc = data_valid_i && b_ready;
      if (b_valid === 1'b1) begin
        logic signed [DW-1:0] e;
        logic [1:0] ep;
        ep = out_cnt[1:0];
        e = (ep == 2'd0) ? DW'(out_cnt / 4 + 1) : '0;
        checks++;
        if (b_data !== e || b_phase !== ep) begin
          errors++;
          $display("FAIL bp_out%0d: got data=%0d phase=%0d, want %0d %0d", out_cnt, b_data, b_phase, e, ep);
        end
        out_cnt++;
      end
      step();
      if (acc) begin
        sent++;
        data_valid_i = 1'b0;
      end
    end
    checks++;
    if (out_cnt != 24 || sent != 6 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got outputs=%0d accepted=%0d valid=%b, want 24 6 0", out_cnt, sent, b_valid);
    end
  endtask

  task automatic test_random_backpressure();
    logic signed [DW-1:0] q[$];
    int out_cnt;
    int n_in;
    bit in_acc;
    bit out_acc;
    bit extra;
    do_reset();
    out_cnt = 0;
    n_in = 0;
    for (int cyc = 0; cyc < 20000 && out_cnt < 1600; cyc++) begin
      data_ready_i = 1'($urandom_range(0, 1));
      data_valid_i = (n_in < 100) && ($urandom_range(0, 1) == 1);
      data_in = DW'($urandom);
      in_acc = data_valid_i && d_ready;
      out_acc = d_valid && data_ready_i;
      if (out_acc) begin
        int idx;
        logic signed [DW-1:0] e;
        logic [3:0] ep;
        idx = out_cnt / 16;
        ep = out_cnt[3:0];
        checks++;
        if (idx >= q.size()) begin
          errors++;
          $display("FAIL rnd_out%0d: unexpected output data=%h phase=%0d", out_cnt, d_data, d_phase);
        end else begin
          e = (ep == 4'd0) ? q[idx] : '0;
          if (d_data !== e || d_phase !== ep) begin
            errors++;
            $display("FAIL rnd_out%0d: got data=%h phase=%0d, want %h %0d", out_cnt, d_data, d_phase, e, ep);
          end
        end
        out_cnt++;
      end
      if (in_acc) begin
        q.push_back(data_in);
        n_in++;
      end
      step();
    end
    data_valid_i = 1'b0;
    data_ready_i = 1'b1;
    extra = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (d_valid !== 1'b0) extra = 1'b1;
      step();
    end
    checks++;
    if (out_cnt != 1600 || n_in != 100 || extra) begin
      errors++;
      $display("FAIL rnd_totals: got outputs=%0d inputs=%0d extra=%b, want 1600 100 0", out_cnt, n_in, extra);
    end
  endtask

  task automatic test_reset_midframe();
    bit stale;
    do_reset();
    data_ready_i = 1'b1;
    data_valid_i = 1'b1;
    data_in = 26'h00000A1;
    step();
    data_in = 26'h00000A2;
    step();
    data_in = 26'h00000A3;
    step();
    data_valid_i = 1'b0;
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (d_valid !== 1'b1 || d_phase !== 4'd7) begin
      errors++;
      $display("FAIL rstmid_setup: got valid=%b phase=%0d, want 1 7", d_valid, d_phase);
    end
    rst_i = 1'b1;
    step();
    checks++;
    if (d_valid !== 1'b0 || d_phase !== 4'd0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: got valid=%b phase=%0d ready=%b, want 0 0 0", d_valid, d_phase, d_ready);
    end
    rst_i = 1'b0;
    step();
    checks++;
    if (d_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b, want 1", d_ready);
    end
    stale = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (d_valid !== 1'b0) stale = 1'b1;
      step();
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL rstmid_stale: got a valid output after reset, want none");
    end
    data_in = 26'h0000055;
    data_valid_i = 1'b1;
    step();
    data_valid_i = 1'b0;
    step();
    checks++;
    if (d_valid !== 1'b1 || d_data !== 26'sh0000055 || d_phase !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_new: got valid=%b data=%h phase=%0d, want 1 55 0", d_valid, d_data, d_phase);
    end
  endtask

  task automatic test_factor_one();
    do_reset();
    data_ready_i = 1'b1;
    data_valid_i = 1'b1;
    data_in = 26'sd1;
    step();
    data_in = 26'sd2;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL if1_latency_early: got valid=%b, want 0", o_valid);
    end
    step();
    data_in = 26'sd3;
    for (int i = 1; i <= 3; i++) begin
      logic signed [DW-1:0] e;
      e = DW'(i);
      checks++;
      if (o_valid !== 1'b1 || o_data !== e || o_phase !== 1'b0) begin
        errors++;
        $display("FAIL if1_out%0d: got valid=%b data=%0d phase=%0d, want 1 %0d 0", i, o_valid, o_data, o_phase, e);
      end
      if (i == 1) begin
        step();
        data_valid_i = 1'b0;
      end else begin
        step();
      end
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL if1_valid_drop: got %b, want 0", o_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    data_in = '0;
    test_reset();
    test_zero_stuff();
    test_hold();
    test_backpressure();
    test_random_backpressure();
    test_reset_midframe();
    test_factor_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
